mmss_stopwatch_core: RTL and testbench

Stopwatch timekeeping core. It sits between the debounced button/switch conditioners and the display stage, driven by the 1 Hz and 2 Hz clock-enable pulses. It maintains an MM:SS count in BCD, handles run/pause toggling and the adjust mode, and outputs four BCD digits plus adjust/select flags for the display.

---
 rtl/mmss_stopwatch_core_pkg.sv | 31 +++
 rtl/mmss_stopwatch_core_bcd_mod60_counter.sv | 45 ++++
 rtl/mmss_stopwatch_core.sv | 141 ++++++++++++++
 tb/tb_mmss_stopwatch_core.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/mmss_stopwatch_core_pkg.sv
// Shared types and constants for the MM:SS stopwatch core.
package stopwatch_pkg;

    // Width of one BCD digit.
    localparam int BCD_W = 4;

    // Default upper values of the minutes and seconds fields.
    localparam int DEF_MAX_MIN = 59;
    localparam int DEF_MAX_SEC = 59;

    // Largest legal value of a BCD ones digit.
    localparam logic [BCD_W-1:0] BCD_NINE = BCD_W'(9);

    // Top-level operating state.
    typedef enum logic [1:0] {
        RUN    = 2'd0,
        PAUSED = 2'd1,
        ADJUST = 2'd2
    } state_t;

    // Tens digit of a decimal field limit.
    function automatic logic [BCD_W-1:0] tens_of(input int value);
        return BCD_W'(value / 10);
    endfunction

    // Ones digit of a decimal field limit.
    function automatic logic [BCD_W-1:0] ones_of(input int value);
        return BCD_W'(value % 10);
    endfunction

endpackage

// File: rtl/mmss_stopwatch_core_bcd_mod60_counter.sv
// Two-digit BCD field counter. It wraps to 00 after the programmable
// maximum and flags the wrap combinationally so the next field can
// increment in the same cycle.
module bcd_mod60_counter
    import stopwatch_pkg::*;
(
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_inc,
    input  logic [BCD_W-1:0] i_max_tens,
    input  logic [BCD_W-1:0] i_max_ones,
    output logic [BCD_W-1:0] o_tens,
    output logic [BCD_W-1:0] o_ones,
    output logic             o_wrap
);

    logic [BCD_W-1:0] r_tens;
    logic [BCD_W-1:0] r_ones;
    logic             w_at_max;

    assign w_at_max = (r_tens == i_max_tens) && (r_ones == i_max_ones);
    // The wrap is a carry-out: valid only in a cycle where the field increments.
    assign o_wrap   = i_inc && w_at_max;
    assign o_tens   = r_tens;
    assign o_ones   = r_ones;

    // Increment the field; at the field maximum force 00, otherwise ripple ones into tens.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_tens <= '0;
            r_ones <= '0;
        end else if (i_inc) begin
            if (w_at_max) begin
                r_tens <= '0;
                r_ones <= '0;
            end else if (r_ones == BCD_NINE) begin
                r_ones <= '0;
                r_tens <= r_tens + BCD_W'(1);
            end else begin
                r_ones <= r_ones + BCD_W'(1);
            end
        end
    end

endmodule

// File: rtl/mmss_stopwatch_core.sv
// MM:SS stopwatch timekeeping core: run/pause control, adjust mode and
// a chained pair of BCD field counters feeding the display stage.
module mmss_stopwatch_core
    import stopwatch_pkg::*;
#(
    parameter int MAX_MIN      = DEF_MAX_MIN,
    parameter int MAX_SEC      = DEF_MAX_SEC,
    parameter bit START_PAUSED = 1'b0
) (
    input  logic             clk_100mhz,
    input  logic             rst,
    input  logic             clk_1hz,
    input  logic             clk_2hz,
    input  logic             button_pause,
    input  logic             switch_adj,
    input  logic             switch_sel,
    output logic [BCD_W-1:0] bcd_min_tens,
    output logic [BCD_W-1:0] bcd_min_ones,
    output logic [BCD_W-1:0] bcd_sec_tens,
    output logic [BCD_W-1:0] bcd_sec_ones,
    output logic             is_adj,
    output logic             is_sel_sec
);

    localparam logic [BCD_W-1:0] SEC_MAX_TENS = tens_of(MAX_SEC);
    localparam logic [BCD_W-1:0] SEC_MAX_ONES = ones_of(MAX_SEC);
    localparam logic [BCD_W-1:0] MIN_MAX_TENS = tens_of(MAX_MIN);
    localparam logic [BCD_W-1:0] MIN_MAX_ONES = ones_of(MAX_MIN);

    state_t r_state;
    logic   r_run_flag;     // 1 = leave ADJUST into RUN, 0 = into PAUSED
    logic   r_pause_q;
    logic   r_is_adj;
    logic   r_is_sel_sec;

    logic   w_pause_rise;
    logic   w_flag_next;
    logic   w_sec_inc;
    logic   w_min_inc;
    logic   w_sec_wrap;
    logic   w_min_wrap;

    // A held button gives a single rising-edge pulse.
    assign w_pause_rise = button_pause & ~r_pause_q;
    // In ADJUST a pause press flips the state we will return to.
    assign w_flag_next  = r_run_flag ^ w_pause_rise;

    // Seconds count on the 1 Hz tick in RUN, or on the 2 Hz tick in ADJUST when selected.
    assign w_sec_inc = ((r_state == RUN)    & clk_1hz) |
                       ((r_state == ADJUST) & clk_2hz & switch_sel);
    // Minutes take the seconds carry only in RUN; in ADJUST they step on their own.
    assign w_min_inc = ((r_state == RUN)    & w_sec_wrap) |
                       ((r_state == ADJUST) & clk_2hz & ~switch_sel);

    // Register the button for edge detection and the switches for the display flags.
    always_ff @(posedge clk_100mhz or posedge rst) begin
        if (rst) begin
            r_pause_q    <= 1'b0;
            r_is_adj     <= 1'b0;
            r_is_sel_sec <= 1'b0;
        end else begin
            r_pause_q    <= button_pause;
            r_is_adj     <= switch_adj;
            r_is_sel_sec <= switch_sel;
        end
    end

    // Run/pause/adjust state machine; run_flag remembers where ADJUST returns to.
    always_ff @(posedge clk_100mhz or posedge rst) begin
        if (rst) begin
            if (START_PAUSED) begin
                r_state <= PAUSED;
            end else begin
                r_state <= RUN;
            end
            r_run_flag <= ~START_PAUSED;
        end else begin
            case (r_state)
                RUN: begin
                    if (switch_adj) begin
                        r_state    <= ADJUST;
                        r_run_flag <= 1'b1;
                    end else if (w_pause_rise) begin
                        r_state <= PAUSED;
                    end
                end
                PAUSED: begin
                    if (switch_adj) begin
                        r_state    <= ADJUST;
                        r_run_flag <= 1'b0;
                    end else if (w_pause_rise) begin
                        r_state <= RUN;
                    end
                end
                ADJUST: begin
                    r_run_flag <= w_flag_next;
                    if (!switch_adj) begin
                        if (w_flag_next) begin
                            r_state <= RUN;
                        end else begin
                            r_state <= PAUSED;
                        end
                    end
                end
                default: begin
                    r_state <= RUN;
                end
            endcase
        end
    end

    bcd_mod60_counter u_sec (
        .i_clk      (clk_100mhz),
        .i_rst      (rst),
        .i_inc      (w_sec_inc),
        .i_max_tens (SEC_MAX_TENS),
        .i_max_ones (SEC_MAX_ONES),
        .o_tens     (bcd_sec_tens),
        .o_ones     (bcd_sec_ones),
        .o_wrap     (w_sec_wrap)
    );

    bcd_mod60_counter u_min (
        .i_clk      (clk_100mhz),
        .i_rst      (rst),
        .i_inc      (w_min_inc),
        .i_max_tens (MIN_MAX_TENS),
        .i_max_ones (MIN_MAX_ONES),
        .o_tens     (bcd_min_tens),
        .o_ones     (bcd_min_ones),
        .o_wrap     (w_min_wrap)
    );

    assign is_adj     = r_is_adj;
    assign is_sel_sec = r_is_sel_sec;

    // The minutes wrap has no consumer: 59:59 simply rolls to 00:00.
    logic w_unused;
    assign w_unused = w_min_wrap;

endmodule

// File: tb/tb_mmss_stopwatch_core.sv
// Directed bench for mmss_stopwatch_core: a vector table walked in
// segments, with hand-written sequences for held button, flag latency
// and asynchronous reset.
module tb_mmss_stopwatch_core;

    localparam int CLK_HALF = 5;

    // ---------------- clock / reset ----------------
    logic       clk_100mhz = 1'b0;
    logic       rst;
    logic       clk_1hz;
    logic       clk_2hz;
    logic       button_pause;
    logic       switch_adj;
    logic       switch_sel;
    logic [3:0] bcd_min_tens;
    logic [3:0] bcd_min_ones;
    logic [3:0] bcd_sec_tens;
    logic [3:0] bcd_sec_ones;
    logic       is_adj;
    logic       is_sel_sec;

    always #CLK_HALF clk_100mhz = ~clk_100mhz;

    mmss_stopwatch_core dut (
        .clk_100mhz   (clk_100mhz),
        .rst          (rst),
        .clk_1hz      (clk_1hz),
        .clk_2hz      (clk_2hz),
        .button_pause (button_pause),
        .switch_adj   (switch_adj),
        .switch_sel   (switch_sel),
        .bcd_min_tens (bcd_min_tens),
        .bcd_min_ones (bcd_min_ones),
        .bcd_sec_tens (bcd_sec_tens),
        .bcd_sec_ones (bcd_sec_ones),
        .is_adj       (is_adj),
        .is_sel_sec   (is_sel_sec)
    );

    // ---------------- scoreboard ----------------
    int          total = 0;
    int          bad = 0;
    int          illegal_cnt = 0;
    logic [15:0] exp_q[$];

    function automatic logic [15:0] digits();
        return {bcd_min_tens, bcd_min_ones, bcd_sec_tens, bcd_sec_ones};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Any out-of-range BCD digit while out of reset is recorded.
    always @(negedge clk_100mhz) begin
        if (rst === 1'b0) begin
            if ($isunknown(digits()) || bcd_sec_ones > 4'd9 || bcd_sec_tens > 4'd5 ||
                bcd_min_ones > 4'd9 || bcd_min_tens > 4'd5) begin
                illegal_cnt++;
            end
        end
    end

    // ---------------- vector table ----------------
    typedef enum int {OP_1HZ, OP_2HZ, OP_BOTH, OP_PRESS, OP_1HZ_PRESS, OP_SW} op_t;

    typedef struct {
        op_t         op;
        int          n;
        logic        adj;
        logic        sel;
        logic [15:0] exp_digits;
        logic        exp_adj;
        logic        exp_sel;
    } vec_t;

    vec_t vecs[36];

    function automatic vec_t mk(input op_t op, input int n, input logic adj, input logic sel,
                                input logic [15:0] ed, input logic ea, input logic es);
        vec_t v;
        v.op = op; v.n = n; v.adj = adj; v.sel = sel;
        v.exp_digits = ed; v.exp_adj = ea; v.exp_sel = es;
        return v;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic pulse(input logic one, input logic two, input logic press, input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clk_100mhz);
            clk_1hz = one; clk_2hz = two; button_pause = press;
            @(negedge clk_100mhz);
            clk_1hz = 1'b0; clk_2hz = 1'b0; button_pause = 1'b0;
        end
    endtask

    task automatic set_sw(input logic adj, input logic sel);
        @(negedge clk_100mhz);
        switch_adj = adj; switch_sel = sel;
        @(negedge clk_100mhz);
        @(negedge clk_100mhz);
    endtask

    task automatic apply_vec(input vec_t v);
        case (v.op)
            OP_1HZ:       pulse(1'b1, 1'b0, 1'b0, v.n);
            OP_2HZ:       pulse(1'b0, 1'b1, 1'b0, v.n);
            OP_BOTH:      pulse(1'b1, 1'b1, 1'b0, v.n);
            OP_PRESS:     pulse(1'b0, 1'b0, 1'b1, 1);
            OP_1HZ_PRESS: pulse(1'b1, 1'b0, 1'b1, 1);
            OP_SW:        set_sw(v.adj, v.sel);
            default:      ;
        endcase
    endtask

    task automatic run_table(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            apply_vec(vecs[i]);
            exp_q.push_back(vecs[i].exp_digits);
            check($sformatf("vec%0d_digits", i), 32'(digits()), 32'(exp_q.pop_front()));
            check($sformatf("vec%0d_is_adj", i), 32'(is_adj), 32'(vecs[i].exp_adj));
            check($sformatf("vec%0d_is_sel_sec", i), 32'(is_sel_sec), 32'(vecs[i].exp_sel));
        end
    endtask

    // ---------------- test sequence ----------------
    initial begin
        // Count up, preload 59:58 through ADJUST, roll over, pause/resume.
        vecs[0]  = mk(OP_1HZ,       65, 0, 0, 16'h0105, 0, 0);
        vecs[1]  = mk(OP_SW,         0, 1, 1, 16'h0105, 1, 1);
        vecs[2]  = mk(OP_2HZ,       53, 0, 0, 16'h0158, 1, 1);
        vecs[3]  = mk(OP_SW,         0, 1, 0, 16'h0158, 1, 0);
        vecs[4]  = mk(OP_2HZ,       58, 0, 0, 16'h5958, 1, 0);
        vecs[5]  = mk(OP_1HZ,        2, 0, 0, 16'h5958, 1, 0);
        vecs[6]  = mk(OP_SW,         0, 0, 0, 16'h5958, 0, 0);
        vecs[7]  = mk(OP_1HZ,        1, 0, 0, 16'h5959, 0, 0);
        vecs[8]  = mk(OP_1HZ,        1, 0, 0, 16'h0000, 0, 0);
        vecs[9]  = mk(OP_1HZ,        3, 0, 0, 16'h0003, 0, 0);
        vecs[10] = mk(OP_PRESS,      1, 0, 0, 16'h0003, 0, 0);
        vecs[11] = mk(OP_1HZ,        5, 0, 0, 16'h0003, 0, 0);
        vecs[12] = mk(OP_PRESS,      1, 0, 0, 16'h0003, 0, 0);
        vecs[13] = mk(OP_1HZ,        2, 0, 0, 16'h0005, 0, 0);
        // Advance to 00:58 ahead of the seconds-adjust sequence.
        vecs[14] = mk(OP_1HZ,       52, 0, 0, 16'h0058, 0, 0);
        // Adjust fields, coincident ticks, pause inside ADJUST, simultaneous events.
        vecs[15] = mk(OP_2HZ,        9, 0, 0, 16'h0010, 1, 1);
        vecs[16] = mk(OP_SW,         0, 1, 0, 16'h0010, 1, 0);
        vecs[17] = mk(OP_2HZ,       59, 0, 0, 16'h5910, 1, 0);
        vecs[18] = mk(OP_2HZ,        1, 0, 0, 16'h0010, 1, 0);
        vecs[19] = mk(OP_1HZ,        3, 0, 0, 16'h0010, 1, 0);
        vecs[20] = mk(OP_BOTH,       1, 0, 0, 16'h0110, 1, 0);
        vecs[21] = mk(OP_PRESS,      1, 0, 0, 16'h0110, 1, 0);
        vecs[22] = mk(OP_SW,         0, 0, 0, 16'h0110, 0, 0);
        vecs[23] = mk(OP_1HZ,        2, 0, 0, 16'h0110, 0, 0);
        vecs[24] = mk(OP_1HZ_PRESS,  1, 0, 0, 16'h0110, 0, 0);
        vecs[25] = mk(OP_1HZ,        1, 0, 0, 16'h0111, 0, 0);
        vecs[26] = mk(OP_1HZ_PRESS,  1, 0, 0, 16'h0112, 0, 0);
        vecs[27] = mk(OP_1HZ,        1, 0, 0, 16'h0112, 0, 0);
        vecs[28] = mk(OP_2HZ,        2, 0, 0, 16'h0112, 0, 0);
        vecs[29] = mk(OP_PRESS,      1, 0, 0, 16'h0112, 0, 0);
        vecs[30] = mk(OP_2HZ,        3, 0, 0, 16'h0112, 0, 0);
        vecs[31] = mk(OP_1HZ,        1, 0, 0, 16'h0113, 0, 0);
        vecs[32] = mk(OP_SW,         0, 1, 0, 16'h0113, 1, 0);
        vecs[33] = mk(OP_2HZ,       11, 0, 0, 16'h1213, 1, 0);
        vecs[34] = mk(OP_SW,         0, 1, 1, 16'h1213, 1, 1);
        vecs[35] = mk(OP_2HZ,       21, 0, 0, 16'h1234, 1, 1);

        rst = 1'b1;
        clk_1hz = 1'b0; clk_2hz = 1'b0; button_pause = 1'b0;
        switch_adj = 1'b0; switch_sel = 1'b0;
        repeat (3) @(negedge clk_100mhz);
        check("reset_digits", 32'(digits()), 32'h0);
        check("reset_is_adj", 32'(is_adj), 32'h0);
        check("reset_is_sel_sec", 32'(is_sel_sec), 32'h0);
        rst = 1'b0;
        @(negedge clk_100mhz);

        run_table(0, 13);

        // Button held for 1000 cycles: exactly one toggle (RUN -> PAUSED).
        @(negedge clk_100mhz);
        button_pause = 1'b1;
        repeat (1000) @(negedge clk_100mhz);
        button_pause = 1'b0;
        @(negedge clk_100mhz);
        pulse(1'b1, 1'b0, 1'b0, 2);
        check("hold_paused", 32'(digits()), 32'h0005);
        pulse(1'b0, 1'b0, 1'b1, 1);
        pulse(1'b1, 1'b0, 1'b0, 1);
        check("hold_resumed", 32'(digits()), 32'h0006);

        run_table(14, 14);

        // Flags follow the switches one cycle later; seconds-only adjust wraps without carry.
        @(negedge clk_100mhz);
        switch_adj = 1'b1; switch_sel = 1'b1;
        #1;
        check("adj_lat_before", 32'(is_adj), 32'h0);
        check("sel_lat_before", 32'(is_sel_sec), 32'h0);
        @(negedge clk_100mhz);
        check("adj_lat_after", 32'(is_adj), 32'h1);
        check("sel_lat_after", 32'(is_sel_sec), 32'h1);
        @(negedge clk_100mhz);
        pulse(1'b0, 1'b1, 1'b0, 3);
        check("adj_sec_wrap", 32'(digits()), 32'h0001);

        run_table(15, 35);

        // Asynchronous reset mid-adjust at 12:34 clears outputs before the next edge.
        @(negedge clk_100mhz);
        #2 rst = 1'b1;
        #1;
        check("async_rst_digits", 32'(digits()), 32'h0);
        check("async_rst_is_adj", 32'(is_adj), 32'h0);
        check("async_rst_is_sel", 32'(is_sel_sec), 32'h0);
        switch_adj = 1'b0; switch_sel = 1'b0;
        @(negedge clk_100mhz);
        @(negedge clk_100mhz);
        rst = 1'b0;
        @(negedge clk_100mhz);
        pulse(1'b1, 1'b0, 1'b0, 1);
        check("post_rst_run", 32'(digits()), 32'h0001);
        check("post_rst_is_adj", 32'(is_adj), 32'h0);

        check("bcd_legal", 32'(illegal_cnt), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
